cla_multiword_seq: RTL and testbench

Sequencer that performs wide additions by streaming 32-bit limbs through the existing 32-bit carry-lookahead adder stage, least-significant limb first. It sits directly upstream and downstream of the CLA. It drives the adder's operand and carry-in pins, then consumes the adder's sum and carry-out, chaining the carry from limb to limb across cycles. It is the team's wide-operand adder for 64/128-bit datapaths, built without widening the CLA.

---
 rtl/cla_multiword_seq_if.sv | 35 +++
 rtl/cla_multiword_seq.sv | 99 +++++++++
 tb/tb_cla_multiword_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cla_multiword_seq_if.sv
// Bundle for the wide-add sequencer: request/result signals plus the limb-level pins
// that loop through an external combinational 32-bit CLA.
`default_nettype none

interface cla_multiword_seq_if #(
  parameter int W     = 32,
  parameter int WORDS = 4
);
  logic                 start;
  logic [W*WORDS-1:0]   a;
  logic [W*WORDS-1:0]   b;
  logic                 ci;
  logic                 busy;
  logic                 done;
  logic [W*WORDS-1:0]   s;
  logic                 co;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic                 add_ci;
  logic [W-1:0]         add_s;
  logic                 add_co;

  // The master side owns the request inputs and also hosts the CLA, so it returns add_s/add_co.
  modport master (
    output start, a, b, ci, add_s, add_co,
    input  busy, done, s, co, add_a, add_b, add_ci
  );

  modport slave (
    input  start, a, b, ci, add_s, add_co,
    output busy, done, s, co, add_a, add_b, add_ci
  );
endinterface

`default_nettype wire

// File: rtl/cla_multiword_seq.sv
// Wide adder built by streaming W-bit limbs (LS limb first) through an external CLA,
// chaining the carry from limb to limb across cycles.
`default_nettype none

module cla_multiword_seq #(
  parameter int W     = 32,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  cla_multiword_seq_if.slave  bus
);

  localparam int                IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int                N        = W * WORDS;
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic [N-1:0]      s_q;
  logic              co_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.ci;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          s_q[idx_q*W +: W] <= bus.add_s;
          carry_q           <= bus.add_co;
          // idx returns to 0 on the last limb so it never leaves 0..WORDS-1.
          if (idx_q == LAST_IDX) begin
            co_q    <= bus.add_co;
            idx_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The CLA result must come back in the same cycle, so the limb selects are driven straight
  // from the state registers rather than through another pipeline register.
  assign bus.add_a  = (state_q == S_RUN) ? a_q[idx_q*W +: W] : '0;
  assign bus.add_b  = (state_q == S_RUN) ? b_q[idx_q*W +: W] : '0;
  assign bus.add_ci = (state_q == S_RUN) ? carry_q : 1'b0;

  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_multiword_seq.sv
// Scoreboard bench for cla_multiword_seq with a behavioural 32-bit adder on the limb pins.
`default_nettype none

module tb_cla_multiword_seq;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  typedef struct {
    logic [N-1:0] s;
    logic         co;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  cla_multiword_seq_if #(.W(W), .WORDS(WORDS)) bus ();

  cla_multiword_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got s=%h co=%b expected no done", bus.s, bus.co);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({bus.co, bus.s} !== {e.co, e.s}) begin
          failures++;
          $display("FAIL result: got co=%b s=%h expected co=%b s=%h", bus.co, bus.s, e.co, e.s);
        end
      end
    end
  end

  // Issues one operation, measures latency/busy, records add_ci per RUN cycle, and optionally
  // fires a second start (a=b=100) in the middle of RUN that must be ignored.
  task automatic do_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic [N-1:0] es, input logic eco,
                       input logic [WORDS-1:0] eci, input bit inject);
    int   cyc;
    int   busy_cnt;
    int   run_k;
    bit   saw;
    logic [WORDS-1:0] ci_seen;
    sb_q.push_back('{s: es, co: eco});
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.ci = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0; busy_cnt = 0; run_k = 0; saw = 0; ci_seen = '0;
    while (!saw && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      if (bus.busy && !bus.done && run_k < WORDS) begin
        ci_seen[run_k] = bus.add_ci;
        run_k++;
      end
      if (bus.done) saw = 1;
      if (inject && cyc == 2) begin
        bus.start = 1'b1; bus.a = N'(100); bus.b = N'(100); bus.ci = 1'b0;
      end
      if (inject && cyc == 3) bus.start = 1'b0;
    end
    check({name, "_done_seen"}, (N+1)'(saw), (N+1)'(1));
    check({name, "_latency"}, (N+1)'(cyc), (N+1)'(WORDS + 1));
    check({name, "_busy_cycles"}, (N+1)'(busy_cnt), (N+1)'(WORDS + 1));
    check({name, "_add_ci_seq"}, (N+1)'(ci_seen), (N+1)'(eci));
    @(negedge clk);
    check({name, "_idle_after"}, (N+1)'({bus.busy, bus.done}), (N+1)'(0));
    bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    repeat (2) @(negedge clk);
    check({name, "_hold"}, {bus.co, bus.s}, {eco, es});
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_s_co", {bus.co, bus.s}, '0);
    check("reset_flags", (N+1)'({bus.busy, bus.done, bus.add_ci}), (N+1)'(0));
    check("reset_add_ab", (N+1)'({bus.add_a, bus.add_b}), (N+1)'(0));
    rst = 1'b0;

    do_op("small", N'(9), N'(4), 1'b0, N'(13), 1'b0, 4'b0000, 1'b0);
    do_op("ripple", {N{1'b1}}, N'(1), 1'b0, '0, 1'b1, 4'b1110, 1'b0);
    do_op("ci_only", N'(64'h0000_0000_FFFF_FFFF), '0, 1'b1, N'(64'h1_0000_0000), 1'b0, 4'b0011, 1'b0);
    do_op("ignore_start", N'(5), N'(6), 1'b0, N'(11), 1'b0, 4'b0000, 1'b1);
    repeat (6) @(negedge clk);

    // Abort mid-operation: no done may appear and everything returns to reset values.
    @(posedge clk); #1;
    bus.a = {N{1'b1}}; bus.b = {N{1'b1}}; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_s_co", {bus.co, bus.s}, '0);
    check("abort_flags", (N+1)'({bus.busy, bus.done, bus.add_ci}), (N+1)'(0));
    @(negedge clk);
    rst = 1'b0;
    begin
      bit done_seen;
      done_seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.done) done_seen = 1;
      end
      check("abort_no_done", (N+1)'(done_seen), (N+1)'(0));
    end

    do_op("after_abort", {N{1'b1}}, {N{1'b1}}, 1'b0, {{(N-1){1'b1}}, 1'b0}, 1'b1, 4'b1110, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", (N+1)'(sb_q.size()), (N+1)'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
